// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - runtime-configurable UART transmitter (5-8 data bits, parity, 1/2 stop) with write FIFO
// Optional line break control: define UART_TX_BREAK_EN to add break_i.
module uart_tx_cfg #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
`ifdef UART_TX_BREAK_EN
    input  logic                          break_i,
`endif
    input  logic [DIV_WIDTH-1:0]          baud_div_i,
    input  logic [1:0]                    data_bits_i,
    input  logic [1:0]                    parity_i,
    input  logic                          stop2_i,
    input  logic                          tx_en_i,
    input  logic                          tx_we_i,
    input  logic [7:0]                    din_i,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          ovf_o,
    output logic                          busy_o,
    output logic                          tx_bit_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0]     PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 ovf_q;
    logic                 push, pop, empty, full;

    logic [7:0]           data_q;
    logic [1:0]           nbits_q;
    logic [1:0]           par_q;
    logic                 stop2_q;
    logic [DIV_WIDTH-1:0] div_q, tmr_q, div_eff;
    logic [2:0]           bit_idx_q;
    logic                 stop_cnt_q;

    logic                 brk;
    logic                 start_ok, bit_end, data_last, stop_last, par_en, par_bit;
    logic                 line;

`ifdef UART_TX_BREAK_EN
    assign brk = break_i;
`else
    assign brk = 1'b0;
`endif

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign push    = tx_we_i && (!full || pop);
    assign div_eff = (baud_div_i == '0) ? DIV_ONE : baud_div_i;

    assign start_ok  = tx_en_i && !empty && !brk;
    assign bit_end   = (tmr_q == '0);
    assign data_last = (bit_idx_q == ({1'b0, nbits_q} + 3'd4));
    assign stop_last = (stop_cnt_q == stop2_q);
    assign par_en    = par_q[0] ^ par_q[1];
    // Only the configured data bits contribute; odd parity (10) inverts via par_q[1].
    assign par_bit   = (^(data_q & (8'hFF >> (2'd3 - nbits_q)))) ^ par_q[1];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            ovf_q <= tx_we_i && full && !pop;
        end
    end

    // Frame datapath: format and divisor are captured at pop so later config writes cannot disturb it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q     <= '0;
            nbits_q    <= '0;
            par_q      <= '0;
            stop2_q    <= 1'b0;
            div_q      <= DIV_ONE;
            tmr_q      <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            if (pop) begin
                data_q  <= mem_q[rd_ptr_q];
                nbits_q <= data_bits_i;
                par_q   <= parity_i;
                stop2_q <= stop2_i;
                div_q   <= div_eff;
                tmr_q   <= div_eff - DIV_ONE;
            end else if (state_q != IDLE) begin
                tmr_q <= bit_end ? (div_q - DIV_ONE) : (tmr_q - DIV_ONE);
            end

            if (state_q == START) begin
                bit_idx_q <= '0;
            end else if (state_q == DATA && bit_end) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end

            if (state_q != STOP) begin
                stop_cnt_q <= 1'b0;
            end else if (bit_end) begin
                stop_cnt_q <= ~stop_cnt_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end && data_last) begin
                    state_d = par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Back-to-back: the next start bit follows the last stop cycle directly.
                if (bit_end && stop_last) begin
                    if (start_ok) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        line = 1'b1;
        case (state_q)
            IDLE:    line = 1'b1;
            START:   line = 1'b0;
            DATA:    line = data_q[bit_idx_q];
            PARITY:  line = par_bit;
            STOP:    line = 1'b1;
            default: line = 1'b1;
        endcase
    end

    assign tx_bit_o = line & ~brk;
    assign busy_o   = (state_q != IDLE);
    assign empty_o  = empty;
    assign full_o   = full;
    assign level_o  = count_q;
    assign ovf_o    = ovf_q;

endmodule
